// File: rtl/data_mem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// Optional timeout watchdog is enabled with the MEM_ARB_TIMEOUT_EN macro.
package data_mem_arb_pkg;

   localparam int unsigned DEF_ADDR_W      = 8;
   localparam int unsigned DEF_DATA_W      = 8;
   localparam int unsigned DEF_TIMEOUT_CYC = 255;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DBG = 1'b1
   } owner_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// WAIT-state timeout counter with a sticky error flag.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog
   import data_mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic   clk,
   input  logic   rst_n,
   input  state_t state,
   input  logic   mem_busy,
   output logic   timeout,
   output logic   err
);

   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;

   always_comb begin
      cnt_d = cnt_q;
      if (state == ISSUE) begin
         cnt_d = 8'd0;
      end else if (state == WAIT && cnt_q != 8'hFF) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Fires in the WAIT cycle whose increment brings the count to the limit.
   assign timeout = (state == WAIT) && mem_busy && (cnt_d == 8'(TIMEOUT_CYC));

   always_comb begin
      err_d = err_q | timeout;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one multi-cycle data memory between the CPU and a debug port.
// Define MEM_ARB_TIMEOUT_EN to add the WAIT-state watchdog and sticky ERR flag.
module data_mem_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              CPU_READ,
   input  logic              CPU_WRITE,
   input  logic [ADDR_W-1:0] CPU_ADDR,
   input  logic [DATA_W-1:0] CPU_WRITEDATA,
   output logic [DATA_W-1:0] CPU_READDATA,
   output logic              CPU_BUSYWAIT,
   input  logic              DBG_READ,
   input  logic              DBG_WRITE,
   input  logic [ADDR_W-1:0] DBG_ADDR,
   input  logic [DATA_W-1:0] DBG_WRITEDATA,
   output logic [DATA_W-1:0] DBG_READDATA,
   output logic              DBG_BUSYWAIT,
   output logic              MEM_READ,
   output logic              MEM_WRITE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WRITEDATA,
   input  logic [DATA_W-1:0] MEM_READDATA,
   input  logic              MEM_BUSYWAIT,
   output logic              ERR,
   output state_t            fsm_state
);

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d;
   owner_t            last_owner_q, last_owner_d;
   owner_t            grant;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
   logic [DATA_W-1:0] fill_data;
   logic              cpu_req, dbg_req, grant_wr, owner_rd, timeout;

   assign cpu_req = CPU_READ | CPU_WRITE;
   assign dbg_req = DBG_READ | DBG_WRITE;

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant = OWN_DBG;
      if (cpu_req && dbg_req) begin
         grant = (last_owner_q == OWN_DBG) ? OWN_CPU : OWN_DBG;
      end else if (cpu_req) begin
         grant = OWN_CPU;
      end
   end

   assign grant_wr  = (grant == OWN_CPU) ? CPU_WRITE : DBG_WRITE;
   assign owner_rd  = (owner_q == OWN_CPU) ? CPU_READ : DBG_READ;
   assign fill_data = MEM_BUSYWAIT ? {DATA_W{1'b1}} : MEM_READDATA;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      cpu_rdata_d  = cpu_rdata_q;
      dbg_rdata_d  = dbg_rdata_q;
      case (state_q)
         IDLE: begin
            if (cpu_req || dbg_req) begin
               owner_d     = grant;
               mem_addr_d  = (grant == OWN_CPU) ? CPU_ADDR : DBG_ADDR;
               mem_wdata_d = (grant == OWN_CPU) ? CPU_WRITEDATA : DBG_WRITEDATA;
               mem_write_d = grant_wr;
               mem_read_d  = !grant_wr;
               state_d     = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (!MEM_BUSYWAIT || timeout) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               state_d     = DONE;
               // A requester that withdrew its read gets nothing back.
               if (mem_read_q && owner_rd) begin
                  if (owner_q == OWN_CPU) cpu_rdata_d = fill_data;
                  else                    dbg_rdata_d = fill_data;
               end
            end
         end
         DONE: begin
            last_owner_d = owner_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q      <= IDLE;
         owner_q      <= OWN_DBG;
         last_owner_q <= OWN_DBG;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   mem_arb_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .clk      (CLK),
      .rst_n    (RESET),
      .state    (state_q),
      .mem_busy (MEM_BUSYWAIT),
      .timeout  (timeout),
      .err      (ERR)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYC;
   assign timeout            = 1'b0;
   assign ERR                = 1'b0;
`endif

   assign CPU_BUSYWAIT  = cpu_req && !(state_q == DONE && owner_q == OWN_CPU);
   assign DBG_BUSYWAIT  = dbg_req && !(state_q == DONE && owner_q == OWN_DBG);
   assign CPU_READDATA  = cpu_rdata_q;
   assign DBG_READDATA  = dbg_rdata_q;
   assign MEM_READ      = mem_read_q;
   assign MEM_WRITE     = mem_write_q;
   assign MEM_ADDR      = mem_addr_q;
   assign MEM_WRITEDATA = mem_wdata_q;
   assign fsm_state     = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small busy-count memory model.
// Build with MEM_ARB_TIMEOUT_EN defined to also exercise the watchdog abort.
module tb_data_mem_arbiter;
   import data_mem_arb_pkg::*;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int unsigned TO_CYC = 4;
`else
   localparam int unsigned TO_CYC = 255;
`endif

   logic       CLK, RESET;
   logic       CPU_READ, CPU_WRITE, CPU_BUSYWAIT;
   logic [7:0] CPU_ADDR, CPU_WRITEDATA, CPU_READDATA;
   logic       DBG_READ, DBG_WRITE, DBG_BUSYWAIT;
   logic [7:0] DBG_ADDR, DBG_WRITEDATA, DBG_READDATA;
   logic       MEM_READ, MEM_WRITE, MEM_BUSYWAIT, ERR;
   logic [7:0] MEM_ADDR, MEM_WRITEDATA, MEM_READDATA;
   state_t     fsm_state;

   int         n_vec = 0;
   int         n_err = 0;
   int         busy_n = 0;
   int         stb_cnt = 0;
   logic [7:0] rd_data = 8'h00;

   data_mem_arbiter #(
      .ADDR_W      (8),
      .DATA_W      (8),
      .TIMEOUT_CYC (TO_CYC)
   ) dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .CPU_READ      (CPU_READ),
      .CPU_WRITE     (CPU_WRITE),
      .CPU_ADDR      (CPU_ADDR),
      .CPU_WRITEDATA (CPU_WRITEDATA),
      .CPU_READDATA  (CPU_READDATA),
      .CPU_BUSYWAIT  (CPU_BUSYWAIT),
      .DBG_READ      (DBG_READ),
      .DBG_WRITE     (DBG_WRITE),
      .DBG_ADDR      (DBG_ADDR),
      .DBG_WRITEDATA (DBG_WRITEDATA),
      .DBG_READDATA  (DBG_READDATA),
      .DBG_BUSYWAIT  (DBG_BUSYWAIT),
      .MEM_READ      (MEM_READ),
      .MEM_WRITE     (MEM_WRITE),
      .MEM_ADDR      (MEM_ADDR),
      .MEM_WRITEDATA (MEM_WRITEDATA),
      .MEM_READDATA  (MEM_READDATA),
      .MEM_BUSYWAIT  (MEM_BUSYWAIT),
      .ERR           (ERR),
      .fsm_state     (fsm_state)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Memory model: busy for busy_n WAIT cycles after the ISSUE cycle.
   always @(posedge CLK) begin
      if (MEM_READ | MEM_WRITE) stb_cnt <= stb_cnt + 1;
      else                      stb_cnt <= 0;
   end
   assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (stb_cnt < busy_n + 1);
   assign MEM_READDATA = rd_data;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   initial begin
      RESET = 1'b0;
      CPU_READ = 1'b0; CPU_WRITE = 1'b0; CPU_ADDR = 8'h00; CPU_WRITEDATA = 8'h00;
      DBG_READ = 1'b0; DBG_WRITE = 1'b0; DBG_ADDR = 8'h00; DBG_WRITEDATA = 8'h00;
      tick(2);
      check_eq("rst_state", 32'(fsm_state), 32'(IDLE));
      check_eq("rst_mem_read", 32'(MEM_READ), 0);
      check_eq("rst_mem_write", 32'(MEM_WRITE), 0);
      check_eq("rst_mem_addr", 32'(MEM_ADDR), 0);
      check_eq("rst_mem_wdata", 32'(MEM_WRITEDATA), 0);
      check_eq("rst_cpu_rdata", 32'(CPU_READDATA), 0);
      check_eq("rst_dbg_rdata", 32'(DBG_READDATA), 0);
      check_eq("rst_err", 32'(ERR), 0);
      check_eq("rst_cpu_bw", 32'(CPU_BUSYWAIT), 0);
      RESET = 1'b1;
      tick(1);

      // 1: CPU read, zero-wait memory
      CPU_READ = 1'b1; CPU_ADDR = 8'h10; rd_data = 8'hA5; busy_n = 0;
      #1 check_eq("t1_bw_c0", 32'(CPU_BUSYWAIT), 1);
      tick(1);
      check_eq("t1_state_c1", 32'(fsm_state), 32'(ISSUE));
      check_eq("t1_rd_c1", 32'(MEM_READ), 1);
      check_eq("t1_addr_c1", 32'(MEM_ADDR), 32'h10);
      check_eq("t1_wr_c1", 32'(MEM_WRITE), 0);
      tick(1);
      check_eq("t1_rd_c2", 32'(MEM_READ), 1);
      check_eq("t1_bw_c2", 32'(CPU_BUSYWAIT), 1);
      tick(1);
      check_eq("t1_bw_c3", 32'(CPU_BUSYWAIT), 0);
      check_eq("t1_rd_c3", 32'(MEM_READ), 0);
      check_eq("t1_rdata_c3", 32'(CPU_READDATA), 32'hA5);
      CPU_READ = 1'b0;
      tick(1);
      check_eq("t1_state_c4", 32'(fsm_state), 32'(IDLE));

      // 2: debug write, memory busy for 4 WAIT cycles
      DBG_WRITE = 1'b1; DBG_ADDR = 8'h20; DBG_WRITEDATA = 8'h3C; busy_n = 4;
      tick(1);
      check_eq("t2_addr", 32'(MEM_ADDR), 32'h20);
      check_eq("t2_wdata", 32'(MEM_WRITEDATA), 32'h3C);
      check_eq("t2_rd", 32'(MEM_READ), 0);
      for (int k = 1; k <= 6; k++) begin
         check_eq($sformatf("t2_wr_c%0d", k), 32'(MEM_WRITE), 1);
         check_eq($sformatf("t2_bw_c%0d", k), 32'(DBG_BUSYWAIT), 1);
         tick(1);
      end
      check_eq("t2_bw_c7", 32'(DBG_BUSYWAIT), 0);
      check_eq("t2_wr_c7", 32'(MEM_WRITE), 0);
      check_eq("t2_err", 32'(ERR), 0);
      DBG_WRITE = 1'b0;
      tick(1);

      // 3: both reads pending, alternating grants starting with CPU
      busy_n = 0;
      CPU_READ = 1'b1; CPU_ADDR = 8'h30;
      DBG_READ = 1'b1; DBG_ADDR = 8'h40;
      for (int i = 0; i < 4; i++) begin
         logic cpu_turn;
         cpu_turn = (i % 2 == 0);
         tick(1);
         check_eq($sformatf("t3_addr_%0d", i), 32'(MEM_ADDR), cpu_turn ? 32'h30 : 32'h40);
         check_eq($sformatf("t3_rd_%0d", i), 32'(MEM_READ), 1);
         rd_data = 8'hC0 + 8'(i);
         tick(2);
         check_eq($sformatf("t3_cpu_bw_%0d", i), 32'(CPU_BUSYWAIT), cpu_turn ? 0 : 1);
         check_eq($sformatf("t3_dbg_bw_%0d", i), 32'(DBG_BUSYWAIT), cpu_turn ? 1 : 0);
         if (cpu_turn) check_eq($sformatf("t3_cpu_rdata_%0d", i), 32'(CPU_READDATA), 32'hC0 + i);
         else          check_eq($sformatf("t3_dbg_rdata_%0d", i), 32'(DBG_READDATA), 32'hC0 + i);
         if (i == 3) begin
            CPU_READ = 1'b0;
            DBG_READ = 1'b0;
         end
         tick(1);
      end
      tick(1);

      // 5: CPU drops its read during WAIT; pending debug read follows
      CPU_READ = 1'b1; CPU_ADDR = 8'h60; rd_data = 8'h77;
      tick(1);
      DBG_READ = 1'b1; DBG_ADDR = 8'h70;
      tick(1);
      CPU_READ = 1'b0;
      tick(1);
      check_eq("t5_state_done", 32'(fsm_state), 32'(DONE));
      check_eq("t5_cpu_rdata_kept", 32'(CPU_READDATA), 32'hC2);
      check_eq("t5_dbg_bw", 32'(DBG_BUSYWAIT), 1);
      tick(2);
      check_eq("t5_dbg_addr", 32'(MEM_ADDR), 32'h70);
      check_eq("t5_dbg_rd", 32'(MEM_READ), 1);
      rd_data = 8'h88;
      tick(2);
      check_eq("t5_dbg_bw_done", 32'(DBG_BUSYWAIT), 0);
      check_eq("t5_dbg_rdata", 32'(DBG_READDATA), 32'h88);
      check_eq("t5_cpu_rdata", 32'(CPU_READDATA), 32'hC2);
      DBG_READ = 1'b0;
      tick(2);

      // 4: reset during WAIT of a CPU write, then reissue
      CPU_WRITE = 1'b1; CPU_ADDR = 8'h50; CPU_WRITEDATA = 8'h99; busy_n = 10;
      tick(2);
      check_eq("t4_state_wait", 32'(fsm_state), 32'(WAIT));
      check_eq("t4_wr_wait", 32'(MEM_WRITE), 1);
      RESET = 1'b0;
      tick(1);
      check_eq("t4_rst_state", 32'(fsm_state), 32'(IDLE));
      check_eq("t4_rst_wr", 32'(MEM_WRITE), 0);
      check_eq("t4_rst_rd", 32'(MEM_READ), 0);
      check_eq("t4_rst_addr", 32'(MEM_ADDR), 0);
      check_eq("t4_rst_wdata", 32'(MEM_WRITEDATA), 0);
      check_eq("t4_rst_bw", 32'(CPU_BUSYWAIT), 1);
      check_eq("t4_rst_cpu_rdata", 32'(CPU_READDATA), 0);
      check_eq("t4_rst_dbg_rdata", 32'(DBG_READDATA), 0);
      check_eq("t4_rst_err", 32'(ERR), 0);
      RESET = 1'b1; busy_n = 0;
      tick(1);
      check_eq("t4_reissue_state", 32'(fsm_state), 32'(ISSUE));
      check_eq("t4_reissue_wr", 32'(MEM_WRITE), 1);
      check_eq("t4_reissue_addr", 32'(MEM_ADDR), 32'h50);
      check_eq("t4_reissue_wdata", 32'(MEM_WRITEDATA), 32'h99);
      tick(2);
      check_eq("t4_done_bw", 32'(CPU_BUSYWAIT), 0);
      CPU_WRITE = 1'b0;
      tick(2);

`ifdef MEM_ARB_TIMEOUT_EN
      // 6: memory stuck busy, watchdog aborts after 4 WAIT cycles
      CPU_READ = 1'b1; CPU_ADDR = 8'h80; busy_n = 255;
      tick(1);
      for (int k = 2; k <= 5; k++) begin
         tick(1);
         check_eq($sformatf("t6_rd_c%0d", k), 32'(MEM_READ), 1);
         check_eq($sformatf("t6_err_c%0d", k), 32'(ERR), 0);
      end
      tick(1);
      check_eq("t6_bw", 32'(CPU_BUSYWAIT), 0);
      check_eq("t6_rd_drop", 32'(MEM_READ), 0);
      check_eq("t6_rdata", 32'(CPU_READDATA), 32'hFF);
      check_eq("t6_err", 32'(ERR), 1);
      CPU_READ = 1'b0;
      tick(3);
      check_eq("t6_err_sticky", 32'(ERR), 1);
      check_eq("t6_state_idle", 32'(fsm_state), 32'(IDLE));
      RESET = 1'b0;
      tick(1);
      RESET = 1'b1;
      check_eq("t6_err_cleared", 32'(ERR), 0);
      tick(1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
